sort_engine: RTL and testbench

//   Parametrised in-place exchange sorter: integrated controller FSM and datapath.

---
 rtl/sort_engine.sv | 200 ++++++++++++++++++++
 tb/tb_sort_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_engine.sv
// In-place exchange sorter for DEPTH words held in an external RAM with
// combinational read and synchronous write. For each i, every later word j
// is compared against M[i] and exchanged when out of order, so M[i] ends up
// holding the extreme value of the remaining range. Direction is chosen per
// run; signed or unsigned compare is fixed per instance.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; swap_cnt holds the last run's total
// LOAD_A | read M[i] into A, set j to i+1
// LOAD_B | read M[j] into B
// CMP    | decide swap, or advance j / i, or finish
// WR_I   | write B into M[i]
// WR_J   | write A into M[j], A takes B, count the swap, then advance
// DONE   | one-cycle done pulse
module sort_engine #(
    parameter int DW     = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int SIGNED = 0,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          desc,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] swap_cnt,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CMP    = 3'd3,
        WR_I   = 3'd4,
        WR_J   = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Terminal indices; i and j stop here rather than wrapping.
    localparam logic [AW-1:0] LAST_I = AW'(DEPTH - 2);
    localparam logic [AW-1:0] LAST_J = AW'(DEPTH - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   i_q, j_q;
    logic [DW-1:0]   a_q, b_q;
    logic            desc_q;

    logic            accept, load_a, load_b, inc_i, inc_j, wr_j, step;
    logic            a_gt_b, b_gt_a, swap_need;
    logic            last_i, last_j;

    // Magnitude compare of the held pair, signed or unsigned per instance.
    generate
        if (SIGNED != 0) begin : g_signed
            assign a_gt_b = $signed(a_q) > $signed(b_q);
            assign b_gt_a = $signed(b_q) > $signed(a_q);
        end else begin : g_unsigned
            assign a_gt_b = a_q > b_q;
            assign b_gt_a = b_q > a_q;
        end
    endgenerate

    // Equal words never swap, which keeps duplicates in place.
    assign swap_need = desc_q ? b_gt_a : a_gt_b;
    assign last_i    = (i_q == LAST_I);
    assign last_j    = (j_q == LAST_J);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, RAM port drive and datapath strobes.
    always_comb begin
        state_d   = state_q;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        accept    = 1'b0;
        load_a    = 1'b0;
        load_b    = 1'b0;
        inc_i     = 1'b0;
        inc_j     = 1'b0;
        wr_j      = 1'b0;
        step      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                mem_addr = i_q;
                load_a   = 1'b1;
                state_d  = LOAD_B;
            end
            LOAD_B: begin
                mem_addr = j_q;
                load_b   = 1'b1;
                state_d  = CMP;
            end
            CMP: begin
                if (swap_need) begin
                    state_d = WR_I;
                end else begin
                    step = 1'b1;
                end
            end
            WR_I: begin
                mem_addr  = i_q;
                mem_wdata = b_q;
                mem_we    = 1'b1;
                state_d   = WR_J;
            end
            WR_J: begin
                mem_addr  = j_q;
                mem_wdata = a_q;
                mem_we    = 1'b1;
                wr_j      = 1'b1;
                step      = 1'b1;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared advance: next j, else next i, else finished.
        if (step) begin
            if (last_j) begin
                if (last_i) begin
                    state_d = DONE;
                end else begin
                    inc_i   = 1'b1;
                    state_d = LOAD_A;
                end
            end else begin
                inc_j   = 1'b1;
                state_d = LOAD_B;
            end
        end
    end

    // Index, operand and swap-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q      <= '0;
            j_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            desc_q   <= 1'b0;
            swap_cnt <= '0;
        end else begin
            if (accept) begin
                i_q      <= '0;
                desc_q   <= desc;
                swap_cnt <= '0;
            end
            if (load_a) begin
                a_q <= mem_rdata;
                j_q <= i_q + 1'b1;
            end
            if (load_b) begin
                b_q <= mem_rdata;
            end
            if (inc_i) begin
                i_q <= i_q + 1'b1;
            end
            if (inc_j) begin
                j_q <= j_q + 1'b1;
            end
            // After the exchange M[i] holds the old B, so A must follow it.
            if (wr_j) begin
                a_q <= b_q;
                if (swap_cnt != '1) begin
                    swap_cnt <= swap_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sort_engine.sv
// Bench for sort_engine: three instances (unsigned depth 8, signed depth 8,
// unsigned depth 2), each with its own behavioural RAM.
module tb_sort_engine;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] start_v;
    logic [2:0] desc_v;
    logic [2:0] busy_w, done_w, we_w;
    logic [15:0] swp_w [3];

    logic [2:0] addr0, addr1;
    logic [0:0] addr2;
    logic [7:0] rd0, rd1, rd2, wd0, wd1, wd2;
    logic [7:0] mem0 [8];
    logic [7:0] mem1 [8];
    logic [7:0] mem2 [2];
    logic [7:0] init0 [8];
    logic [7:0] init1 [8];
    logic [7:0] init2 [2];
    logic [7:0] exp8 [8];
    logic [7:0] exp2 [2];
    logic [2:0] ld;

    int n_checks = 0;
    int n_fail   = 0;
    int lat, nwe;

    always #5 clk = ~clk;

    sort_engine #(.DW(8), .DEPTH(8), .AW(3), .SIGNED(0), .CW(16)) u_uns (
        .clk(clk), .rst(rst), .start(start_v[0]), .desc(desc_v[0]),
        .busy(busy_w[0]), .done(done_w[0]), .swap_cnt(swp_w[0]),
        .mem_addr(addr0), .mem_rdata(rd0), .mem_wdata(wd0), .mem_we(we_w[0])
    );

    sort_engine #(.DW(8), .DEPTH(8), .AW(3), .SIGNED(1), .CW(16)) u_sgn (
        .clk(clk), .rst(rst), .start(start_v[1]), .desc(desc_v[1]),
        .busy(busy_w[1]), .done(done_w[1]), .swap_cnt(swp_w[1]),
        .mem_addr(addr1), .mem_rdata(rd1), .mem_wdata(wd1), .mem_we(we_w[1])
    );

    sort_engine #(.DW(8), .DEPTH(2), .AW(1), .SIGNED(0), .CW(16)) u_two (
        .clk(clk), .rst(rst), .start(start_v[2]), .desc(desc_v[2]),
        .busy(busy_w[2]), .done(done_w[2]), .swap_cnt(swp_w[2]),
        .mem_addr(addr2), .mem_rdata(rd2), .mem_wdata(wd2), .mem_we(we_w[2])
    );

    assign rd0 = mem0[addr0];
    assign rd1 = mem1[addr1];
    assign rd2 = mem2[addr2];

    // RAMs: synchronous write, bench preload through ld.
    always @(posedge clk) begin
        if (ld[0]) mem0 <= init0;
        else if (we_w[0]) mem0[addr0] <= wd0;
        if (ld[1]) mem1 <= init1;
        else if (we_w[1]) mem1[addr1] <= wd1;
        if (ld[2]) mem2 <= init2;
        else if (we_w[2]) mem2[addr2] <= wd2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_load(input int sel);
        @(negedge clk);
        ld[sel] = 1'b1;
        @(negedge clk);
        ld[sel] = 1'b0;
    endtask

    task automatic check_mem(input int sel);
        if (sel == 2) begin
            for (int k = 0; k < 2; k++) check("ram_two", {24'd0, mem2[k]}, {24'd0, exp2[k]});
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (sel == 0) check("ram_uns", {24'd0, mem0[k]}, {24'd0, exp8[k]});
                else          check("ram_sgn", {24'd0, mem1[k]}, {24'd0, exp8[k]});
            end
        end
    endtask

    // Counts cycles from the current sample until done, bounded.
    task automatic wait_done(input int sel, inout int l, inout int w);
        while (done_w[sel] !== 1'b1 && l < 1000) begin
            if (we_w[sel]) w++;
            @(posedge clk); #1;
            l++;
        end
        check("done_seen", {31'd0, done_w[sel]}, 32'd1);
        check("busy_in_done", {31'd0, busy_w[sel]}, 32'd1);
    endtask

    // Cycle 1 is the sample right after the start-accept edge.
    task automatic run_sort(input int sel, input logic d, input bit hold,
                            output int l, output int w);
        @(negedge clk);
        start_v[sel] = 1'b1;
        desc_v[sel]  = d;
        @(posedge clk); #1;
        if (!hold) start_v[sel] = 1'b0;
        check("busy_after_accept", {31'd0, busy_w[sel]}, 32'd1);
        l = 1;
        w = 0;
        wait_done(sel, l, w);
    endtask

    task automatic after_done(input int sel);
        @(posedge clk); #1;
        check("busy_after_done", {31'd0, busy_w[sel]}, 32'd0);
        check("done_single", {31'd0, done_w[sel]}, 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start_v = '0;
        desc_v  = '0;
        ld      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy_w[0]}, 32'd0);
        check("rst_done", {31'd0, done_w[0]}, 32'd0);
        check("rst_we", {31'd0, we_w[0]}, 32'd0);
        check("rst_swap", {16'd0, swp_w[0]}, 32'd0);
        check("rst_addr", {29'd0, addr0}, 32'd0);
        check("rst_wdata", {24'd0, wd0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Mixed data ascending: 13 swaps -> 64 + 26 cycles.
        init0 = '{8'd3, 8'd7, 8'd1, 8'd0, 8'd5, 8'd2, 8'd6, 8'd4};
        pulse_load(0);
        run_sort(0, 1'b0, 1'b0, lat, nwe);
        check("t1_lat", lat, 32'd90);
        check("t1_swap", {16'd0, swp_w[0]}, 32'd13);
        check("t1_writes", nwe, 32'd26);
        after_done(0);
        exp8 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        check_mem(0);
        check("t1_swap_hold", {16'd0, swp_w[0]}, 32'd13);

        // Already sorted: no writes, minimum latency.
        run_sort(0, 1'b0, 1'b0, lat, nwe);
        check("t2_lat", lat, 32'd64);
        check("t2_swap", {16'd0, swp_w[0]}, 32'd0);
        check("t2_writes", nwe, 32'd0);
        after_done(0);
        check_mem(0);

        // Reversed: every pair swaps.
        init0 = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        pulse_load(0);
        run_sort(0, 1'b0, 1'b0, lat, nwe);
        check("t3_lat", lat, 32'd120);
        check("t3_swap", {16'd0, swp_w[0]}, 32'd28);
        after_done(0);
        exp8 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        check_mem(0);

        // Mixed data descending, unsigned.
        init0 = '{8'd3, 8'd7, 8'd1, 8'd0, 8'd5, 8'd2, 8'd6, 8'd4};
        pulse_load(0);
        run_sort(0, 1'b1, 1'b0, lat, nwe);
        after_done(0);
        exp8 = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        check_mem(0);

        // Signed descending.
        init1 = '{8'hFF, 8'h03, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h05, 8'hFB};
        pulse_load(1);
        run_sort(1, 1'b1, 1'b0, lat, nwe);
        after_done(1);
        exp8 = '{8'h7F, 8'h05, 8'h03, 8'h00, 8'h00, 8'hFF, 8'hFB, 8'h80};
        check_mem(1);

        // Start while busy is ignored; reset during the first WR_I.
        init0 = '{8'd3, 8'd7, 8'd1, 8'd0, 8'd5, 8'd2, 8'd6, 8'd4};
        pulse_load(0);
        @(negedge clk);
        start_v[0] = 1'b1;
        desc_v[0]  = 1'b0;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        lat = 1;
        while (we_w[0] !== 1'b1 && lat < 50) begin
            if (lat == 2) start_v[0] = 1'b1;
            if (lat == 3) start_v[0] = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start_v[0] = 1'b0;
        check("t5_wri_cycle", lat, 32'd6);
        check("t5_wri_addr", {29'd0, addr0}, 32'd0);
        check("t5_wri_data", {24'd0, wd0}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_we", {31'd0, we_w[0]}, 32'd0);
        check("t5_rst_busy", {31'd0, busy_w[0]}, 32'd0);
        check("t5_rst_done", {31'd0, done_w[0]}, 32'd0);
        check("t5_rst_addr", {29'd0, addr0}, 32'd0);
        check("t5_rst_wdata", {24'd0, wd0}, 32'd0);
        check("t5_rst_swap", {16'd0, swp_w[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_ram0", {24'd0, mem0[0]}, 32'd3);
        check("t5_ram2", {24'd0, mem0[2]}, 32'd1);

        // Depth 2 with start held across DONE.
        init2 = '{8'd9, 8'd4};
        pulse_load(2);
        run_sort(2, 1'b0, 1'b1, lat, nwe);
        check("t6_lat", lat, 32'd6);
        check("t6_swap", {16'd0, swp_w[2]}, 32'd1);
        check("t6_writes", nwe, 32'd2);
        exp2 = '{8'd4, 8'd9};
        check_mem(2);
        @(posedge clk); #1;
        check("t6_idle_busy", {31'd0, busy_w[2]}, 32'd0);
        check("t6_idle_swap", {16'd0, swp_w[2]}, 32'd1);
        @(posedge clk); #1;
        start_v[2] = 1'b0;
        check("t6_restart_busy", {31'd0, busy_w[2]}, 32'd1);
        check("t6_restart_swap", {16'd0, swp_w[2]}, 32'd0);
        lat = 1;
        nwe = 0;
        wait_done(2, lat, nwe);
        check("t6_lat2", lat, 32'd4);
        check("t6_swap2", {16'd0, swp_w[2]}, 32'd0);
        after_done(2);
        check_mem(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
